// File: rtl/sipo_rx_if.sv
// Bundle between a serial link driver (master) and the sipo_rx deserialiser (slave).
// Strobes: start/shift_en qualify data_in on the rising edge they are high; data_valid,
// overrun and parity_err are outputs only, there is no back-pressure on this link.
interface sipo_rx_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             shift_en;
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic             overrun;
  logic             parity_err;
  logic [1:0]       fsm_state;

  modport master (
    output start, shift_en, data_in,
    input  data_out, data_valid, busy, overrun, parity_err, fsm_state
  );

  modport slave (
    input  start, shift_en, data_in,
    output data_out, data_valid, busy, overrun, parity_err, fsm_state
  );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles a framed bit stream into a WIDTH-bit word.
// Optional even-parity bit per frame when SIPO_PARITY_EN is defined.
module sipo_rx #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic      clk,
  input logic      rst,
  sipo_rx_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             overrun_q;
`ifdef SIPO_PARITY_EN
  logic             perr_q;
`endif

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
    if (MSB_FIRST) return {r[WIDTH-2:0], b};
    else           return {b, r[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      // A start always opens a new frame; outside IDLE it also aborts the current one.
      if (bus.start) begin
        overrun_q <= (state != IDLE);
        shreg     <= shift_in('0, bus.data_in);
        cnt       <= CNT_W'(1);
        state     <= SHIFT;
        busy_q    <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            if (bus.shift_en) begin
              shreg <= shift_in(shreg, bus.data_in);
              cnt   <= cnt + 1'b1;
              if (cnt == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                state <= PARITY;
`else
                data_q  <= shift_in(shreg, bus.data_in);
                valid_q <= 1'b1;
                state   <= IDLE;
                busy_q  <= 1'b0;
`endif
              end
            end
          end
`ifdef SIPO_PARITY_EN
          PARITY: begin
            if (bus.shift_en) begin
              data_q  <= shreg;
              perr_q  <= ^{shreg, bus.data_in};
              valid_q <= 1'b1;
              state   <= IDLE;
              busy_q  <= 1'b0;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.fsm_state  = state;
`ifdef SIPO_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule
